// File: rtl/branch_predict_unit_if.sv
// Pipeline-facing bundle of the branch predictor: ID-stage prediction
// port, EX-stage resolve port and the statistics readout.
interface branch_predict_unit_if #(
    parameter int IW    = 6,
    parameter int CNT_W = 32
);
    logic [31:0]    pred_pc;
    logic           pred_taken;
    logic [IW-1:0]  pred_idx;
    logic           res_valid;
    logic [IW-1:0]  res_idx;
    logic [2:0]     res_op;
    logic [31:0]    res_rd1;
    logic [31:0]    res_rd2;
    logic           res_pred_taken;
    logic           res_taken;
    logic           mispredict;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    modport master (
        output pred_pc, res_valid, res_idx, res_op,
        output res_rd1, res_rd2, res_pred_taken,
        input  pred_taken, pred_idx, res_taken, mispredict,
        input  branch_cnt, mispred_cnt
    );

    modport slave (
        input  pred_pc, res_valid, res_idx, res_op,
        input  res_rd1, res_rd2, res_pred_taken,
        output pred_taken, pred_idx, res_taken, mispredict,
        output branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_predict_unit.sv
// 2-bit saturating-counter branch predictor with EX-stage resolution.
// Define BRANCH_GSHARE_EN to XOR a global history register into the index.
module branch_predict_unit #(
    parameter int PHT_DEPTH = 64,
    parameter int CNT_W     = 32
) (
    input  logic clk,
    input  logic reset,
    branch_predict_unit_if.slave bp
);
    localparam int IW = $clog2(PHT_DEPTH);

    logic [1:0]       r_pht [PHT_DEPTH];
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic signed [31:0] w_a;
    logic signed [31:0] w_b;
    logic               w_qual;
    logic               w_cmp;
    logic               w_taken;
    logic               w_mispred;
    logic [IW-1:0]      w_base_idx;
    logic [IW-1:0]      w_pred_idx;
    logic               w_unused;

    assign w_a        = bp.res_rd1;
    assign w_b        = bp.res_rd2;
    assign w_base_idx = bp.pred_pc[IW+1:2];
    assign w_unused   = ^{bp.pred_pc[31:IW+2], bp.pred_pc[1:0]};

    always_comb begin
        w_qual = 1'b1;
        w_cmp  = 1'b0;
        unique case (bp.res_op)
            3'd1:    w_cmp = (w_a == w_b);
            3'd2:    w_cmp = (w_a != w_b);
            3'd3:    w_cmp = (w_a > 0);
            3'd4:    w_cmp = (w_a >= 0);
            3'd5:    w_cmp = (w_a <= 0);
            3'd6:    w_cmp = (w_a < 0);
            default: w_qual = 1'b0;
        endcase
        w_qual = w_qual & bp.res_valid;
    end

    assign w_taken   = w_qual & w_cmp;
    assign w_mispred = w_qual & (w_taken != bp.res_pred_taken);

`ifdef BRANCH_GSHARE_EN
    logic [IW-1:0] r_ghr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ghr <= '0;
        end else if (w_qual) begin
            r_ghr <= {r_ghr[IW-2:0], w_taken};
        end
    end

    assign w_pred_idx = w_base_idx ^ r_ghr;
`else
    assign w_pred_idx = w_base_idx;
`endif

    // Read is the registered value: a same-index write lands next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PHT_DEPTH; i++) begin
                r_pht[i] <= 2'd1;
            end
        end else if (w_qual) begin
            if (w_taken) begin
                if (r_pht[bp.res_idx] != 2'd3) begin
                    r_pht[bp.res_idx] <= r_pht[bp.res_idx] + 2'd1;
                end
            end else if (r_pht[bp.res_idx] != 2'd0) begin
                r_pht[bp.res_idx] <= r_pht[bp.res_idx] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (w_qual) begin
            if (r_branch_cnt != '1) begin
                r_branch_cnt <= r_branch_cnt + 1'b1;
            end
            if (w_mispred && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + 1'b1;
            end
        end
    end

    assign bp.pred_idx    = w_pred_idx;
    assign bp.pred_taken  = r_pht[w_pred_idx][1];
    assign bp.res_taken   = w_taken;
    assign bp.mispredict  = w_mispred;
    assign bp.branch_cnt  = r_branch_cnt;
    assign bp.mispred_cnt = r_mispred_cnt;
endmodule
